// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache line refill/writeback engine.
//   fill_state_e : FSM encoding of cache_line_fill_wb
//   line_base    : clears the word-offset bits of an address
package cache_pkg;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_WB,
        FS_RD,
        FS_DRAIN,
        FS_DONE
    } fill_state_e;

    // Address with the low iw (word-within-line) bits forced to zero.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned iw);
        return addr & ~((32'd1 << iw) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_line_fill_wb.sv
// Line-granular refill/writeback engine; sole master of the memory
// controller's fetch_mem_* read and write ports.
// A miss request optionally writes back a dirty victim line word by word,
// then reads the new line word by word, streaming each returned word into
// the data array (fill_*). done pulses for one cycle at completion.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        miss request handshake (ready only in IDLE)
//   req_fill_addr, req_wb,
//   req_wb_addr, req_wb_line,
//   req_crit_idx               request payload, latched on accept
//   fill_we/widx/wdata         data-array write port
//   done                       one-cycle completion pulse
//   fetch_mem_r*               memory read port (data valid 1 cycle after handshake)
//   fetch_mem_w*               memory write port
//
// Configuration macro:
//   CACHE_FILL_CRIT_FIRST_EN   when defined, reads/fills start at the latched
//                              critical word index and wrap around the line;
//                              otherwise order is 0..LINE_WORDS-1.
module cache_line_fill_wb
    import cache_pkg::*;
#(
    parameter  int MEM_DEPTH  = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int LINE_WORDS = 4,
    localparam int AW         = $clog2(MEM_DEPTH),
    localparam int IW         = $clog2(LINE_WORDS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [AW-1:0]                    req_fill_addr,
    input  logic                             req_wb,
    input  logic [AW-1:0]                    req_wb_addr,
    input  logic [DATA_WIDTH*LINE_WORDS-1:0] req_wb_line,
    input  logic [IW-1:0]                    req_crit_idx,
    output logic                             fill_we,
    output logic [IW-1:0]                    fill_widx,
    output logic [DATA_WIDTH-1:0]            fill_wdata,
    output logic                             done,
    output logic [AW-1:0]                    fetch_mem_raddr,
    output logic                             fetch_mem_ren,
    input  logic                             fetch_mem_rready,
    input  logic [DATA_WIDTH-1:0]            fetch_mem_rdata,
    input  logic                             fetch_mem_rdata_valid,
    output logic [AW-1:0]                    fetch_mem_waddr,
    output logic                             fetch_mem_wen,
    input  logic                             fetch_mem_wready,
    output logic [DATA_WIDTH-1:0]            fetch_mem_wdata
);

    localparam logic [IW:0] LAST_W = (IW+1)'(LINE_WORDS - 1);
    localparam logic [IW:0] FULL_W = (IW+1)'(LINE_WORDS);

    fill_state_e state, state_next;

    logic [AW-1:0]                    fill_base;
    logic [AW-1:0]                    wb_base;
    logic [DATA_WIDTH*LINE_WORDS-1:0] wb_line;
    logic [IW-1:0]                    start;
    logic [IW:0]                      wcnt;
    logic [IW:0]                      issued;
    logic [IW:0]                      rcnt;
    logic [IW-1:0]                    ridx;
    logic [DATA_WIDTH-1:0]            wb_word;
    logic                             accept;

    assign accept = req_valid && req_ready;
    // Index arithmetic is IW bits wide, so it wraps modulo LINE_WORDS and
    // never carries into the line tag bits of the address.
    assign ridx   = start + issued[IW-1:0];

`ifdef CACHE_FILL_CRIT_FIRST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      start <= '0;
        else if (accept) start <= req_crit_idx;
    end
`else
    logic unused_crit;
    assign unused_crit = ^req_crit_idx;
    assign start       = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_base <= '0;
            wb_base   <= '0;
            wb_line   <= '0;
            wcnt      <= '0;
            issued    <= '0;
            rcnt      <= '0;
        end else if (accept) begin
            fill_base <= AW'(line_base(32'(req_fill_addr), IW));
            wb_base   <= AW'(line_base(32'(req_wb_addr), IW));
            wb_line   <= req_wb_line;
            wcnt      <= '0;
            issued    <= '0;
            rcnt      <= '0;
        end else begin
            if (fetch_mem_wen && fetch_mem_wready) wcnt   <= wcnt + 1'b1;
            if (fetch_mem_ren && fetch_mem_rready) issued <= issued + 1'b1;
            if (fill_we)                           rcnt   <= rcnt + 1'b1;
        end
    end

    always_comb begin
        wb_word = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (wcnt[IW-1:0] == IW'(i)) wb_word = wb_line[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        done            = 1'b0;
        fill_we         = 1'b0;
        fill_widx       = '0;
        fill_wdata      = '0;
        fetch_mem_ren   = 1'b0;
        fetch_mem_raddr = '0;
        fetch_mem_wen   = 1'b0;
        fetch_mem_waddr = '0;
        fetch_mem_wdata = '0;

        // Returns are only accepted while reads can be outstanding, so a
        // spurious rdata_valid in other states never reaches the data array.
        if (state == FS_RD || state == FS_DRAIN) begin
            fill_we    = fetch_mem_rdata_valid;
            fill_widx  = start + rcnt[IW-1:0];
            fill_wdata = fetch_mem_rdata;
        end

        case (state)
            FS_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_wb ? FS_WB : FS_RD;
            end
            FS_WB: begin
                fetch_mem_wen   = 1'b1;
                fetch_mem_waddr = wb_base | AW'(wcnt[IW-1:0]);
                fetch_mem_wdata = wb_word;
                if (fetch_mem_wready && wcnt == LAST_W) state_next = FS_RD;
            end
            FS_RD: begin
                fetch_mem_ren   = (issued < FULL_W);
                fetch_mem_raddr = fill_base | AW'(ridx);
                if (fetch_mem_ren && fetch_mem_rready && issued == LAST_W) state_next = FS_DRAIN;
            end
            FS_DRAIN: begin
                // Count the return arriving this cycle so the final word may
                // land in the first DRAIN cycle.
                if ((rcnt + (IW+1)'(fill_we)) == FULL_W) state_next = FS_DONE;
            end
            FS_DONE: begin
                done       = 1'b1;
                state_next = FS_IDLE;
            end
            default: state_next = FS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_line_fill_wb.sv
// Directed self-checking bench for cache_line_fill_wb (32 words, 4-word lines).
// Memory model: one-cycle read latency; unwritten words read as 32'hA000_0000|addr.
module tb_cache_line_fill_wb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int IW = 2;
`ifdef CACHE_FILL_CRIT_FIRST_EN
    localparam int CRIT_ON = 1;
`else
    localparam int CRIT_ON = 0;
`endif

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_fill_addr;
    logic           req_wb;
    logic [AW-1:0]  req_wb_addr;
    logic [DW*LW-1:0] req_wb_line;
    logic [IW-1:0]  req_crit_idx;
    logic           fill_we;
    logic [IW-1:0]  fill_widx;
    logic [DW-1:0]  fill_wdata;
    logic           done;
    logic [AW-1:0]  fetch_mem_raddr;
    logic           fetch_mem_ren;
    logic           fetch_mem_rready;
    logic [DW-1:0]  fetch_mem_rdata;
    logic           fetch_mem_rdata_valid;
    logic [AW-1:0]  fetch_mem_waddr;
    logic           fetch_mem_wen;
    logic           fetch_mem_wready;
    logic [DW-1:0]  fetch_mem_wdata;

    cache_line_fill_wb #(.MEM_DEPTH(32), .DATA_WIDTH(32), .LINE_WORDS(4)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_fill_addr         (req_fill_addr),
        .req_wb                (req_wb),
        .req_wb_addr           (req_wb_addr),
        .req_wb_line           (req_wb_line),
        .req_crit_idx          (req_crit_idx),
        .fill_we               (fill_we),
        .fill_widx             (fill_widx),
        .fill_wdata            (fill_wdata),
        .done                  (done),
        .fetch_mem_raddr       (fetch_mem_raddr),
        .fetch_mem_ren         (fetch_mem_ren),
        .fetch_mem_rready      (fetch_mem_rready),
        .fetch_mem_rdata       (fetch_mem_rdata),
        .fetch_mem_rdata_valid (fetch_mem_rdata_valid),
        .fetch_mem_waddr       (fetch_mem_waddr),
        .fetch_mem_wen         (fetch_mem_wen),
        .fetch_mem_wready      (fetch_mem_wready),
        .fetch_mem_wdata       (fetch_mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'hA000_0000 | 32'(a);
    endfunction

    // ---------------- memory model and grant generation ----------------
    logic [DW-1:0] mem [32];
    logic          wr_flag [32];
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          spur_en = 1'b0;
    logic          rtoggle = 1'b0;
    logic          stall_en = 1'b0;
    int            stall_cnt;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        m_rvalid <= fetch_mem_ren && fetch_mem_rready;
        if (fetch_mem_ren && fetch_mem_rready)
            m_rdata <= (wr_flag[fetch_mem_raddr] === 1'b1) ? mem[fetch_mem_raddr] : pat(int'(fetch_mem_raddr));
        if (fetch_mem_wen && fetch_mem_wready) begin
            mem[fetch_mem_waddr]     <= fetch_mem_wdata;
            wr_flag[fetch_mem_waddr] <= 1'b1;
        end
        fetch_mem_rready <= rtoggle ? ~fetch_mem_rready : 1'b1;
        if (!stall_en) stall_cnt <= 0;
        else if (fetch_mem_wen && fetch_mem_waddr[1:0] == 2'd2 && stall_cnt < 3) stall_cnt <= stall_cnt + 1;
    end

    assign fetch_mem_wready      = !(stall_en && fetch_mem_wen && fetch_mem_waddr[1:0] == 2'd2 && stall_cnt < 3);
    assign fetch_mem_rdata_valid = m_rvalid | (spur_en & fetch_mem_wen);
    assign fetch_mem_rdata       = m_rdata;

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [31:0] fq_idx[$], fq_data[$], rq_addr[$], wq_addr[$], wq_data[$];
    int          fq_cyc[$], rq_cyc[$], wq_cyc[$], dq_cyc[$];
    int          acc_cyc, spur_bad = 0, stab_bad = 0;
    logic        p_wstall = 1'b0, p_rstall = 1'b0;
    logic [AW-1:0] p_waddr, p_raddr;
    logic [DW-1:0] p_wdata;

    always @(negedge clk) begin
        if (fill_we) begin
            fq_idx.push_back(32'(fill_widx));
            fq_data.push_back(fill_wdata);
            fq_cyc.push_back(cyc);
            if (fetch_mem_wen) spur_bad++;
        end
        if (fetch_mem_ren && fetch_mem_rready) begin
            rq_addr.push_back(32'(fetch_mem_raddr));
            rq_cyc.push_back(cyc);
        end
        if (fetch_mem_wen && fetch_mem_wready) begin
            wq_addr.push_back(32'(fetch_mem_waddr));
            wq_data.push_back(fetch_mem_wdata);
            wq_cyc.push_back(cyc);
        end
        if (done) dq_cyc.push_back(cyc);
        if (req_valid && req_ready) acc_cyc = cyc;
        if (p_wstall && (!fetch_mem_wen || fetch_mem_waddr != p_waddr || fetch_mem_wdata != p_wdata)) stab_bad++;
        if (p_rstall && (!fetch_mem_ren || fetch_mem_raddr != p_raddr)) stab_bad++;
        p_wstall = fetch_mem_wen && !fetch_mem_wready;
        p_rstall = fetch_mem_ren && !fetch_mem_rready;
        p_waddr  = fetch_mem_waddr;
        p_wdata  = fetch_mem_wdata;
        p_raddr  = fetch_mem_raddr;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        fq_idx.delete(); fq_data.delete(); fq_cyc.delete();
        rq_addr.delete(); rq_cyc.delete();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        dq_cyc.delete();
    endtask

    task automatic send(input logic [AW-1:0] faddr, input logic wb, input logic [AW-1:0] waddr,
                        input logic [DW*LW-1:0] line, input logic [IW-1:0] crit);
        @(posedge clk); #1;
        clear_logs();
        req_fill_addr = faddr;
        req_wb        = wb;
        req_wb_addr   = waddr;
        req_wb_line   = line;
        req_crit_idx  = crit;
        req_valid     = 1'b1;
        @(posedge clk); #1;
        req_valid     = 1'b0;
        req_wb        = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dq_cyc.size() == 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", 64'(dq_cyc.size() != 0), 64'd1);
        repeat (4) @(posedge clk);
        check("done_once", 64'(dq_cyc.size()), 64'd1);
    endtask

    task automatic check_fills(input string tag, input int base, input int s);
        check({tag, "_nfill"}, 64'(fq_idx.size()), 64'd4);
        for (int i = 0; i < LW; i++) begin
            check({tag, "_fidx"}, 64'(fq_idx[i]), 64'((s + i) % LW));
            check({tag, "_fdata"}, 64'(fq_data[i]), 64'(pat(base + (s + i) % LW)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_fill_we"}, 64'(fill_we), 64'd0);
        check({tag, "_ren"}, 64'(fetch_mem_ren), 64'd0);
        check({tag, "_wen"}, 64'(fetch_mem_wen), 64'd0);
        check({tag, "_addrs"}, 64'({fetch_mem_raddr, fetch_mem_waddr, fill_widx}), 64'd0);
        check({tag, "_data"}, {fetch_mem_wdata, fill_wdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW*LW-1:0] line;
        int s;
        int n;
        int rsz;

        rst_n = 1'b0; req_valid = 1'b0; req_fill_addr = '0; req_wb = 1'b0;
        req_wb_addr = '0; req_wb_line = '0; req_crit_idx = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: clean fill of line 8, grants always high
        send(5'd8, 1'b0, 5'd0, '0, 2'd0);
        wait_done();
        check_fills("clean", 8, 0);
        check("clean_nwr", 64'(wq_addr.size()), 64'd0);
        for (int i = 0; i < LW; i++) begin
            check("clean_raddr", 64'(rq_addr[i]), 64'(8 + i));
            check("clean_rcyc", 64'(rq_cyc[i]), 64'(acc_cyc + 1 + i));
            check("clean_fcyc", 64'(fq_cyc[i]), 64'(acc_cyc + 2 + i));
        end
        check("clean_done_cyc", 64'(dq_cyc[0]), 64'(acc_cyc + 6));

        // 2: dirty eviction of line 4, fill of line 16; spurious rdata_valid during WB
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        spur_en = 1'b1;
        send(5'd16, 1'b1, 5'd4, line, 2'd0);
        wait_done();
        spur_en = 1'b0;
        check("dirty_nwr", 64'(wq_addr.size()), 64'd4);
        for (int i = 0; i < LW; i++) begin
            check("dirty_waddr", 64'(wq_addr[i]), 64'(4 + i));
            check("dirty_wdata", 64'(wq_data[i]), 64'(32'hD000_0000 + 32'(i)));
            check("dirty_wcyc", 64'(wq_cyc[i]), 64'(acc_cyc + 1 + i));
            check("dirty_mem", 64'(mem[4 + i]), 64'(32'hD000_0000 + 32'(i)));
        end
        check("dirty_rd_after_wb", 64'(rq_cyc[0]), 64'(acc_cyc + 5));
        check("dirty_spur", 64'(spur_bad), 64'd0);
        check_fills("dirty", 16, 0);
        check("dirty_done_cyc", 64'(dq_cyc[0]), 64'(acc_cyc + 10));

        // 3: backpressure: wready stalls 3 cycles on word 2, rready toggles
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = 32'hE000_0000 + 32'(i);
        stall_en = 1'b1;
        rtoggle  = 1'b1;
        send(5'd0, 1'b1, 5'd28, line, 2'd0);
        wait_done();
        check("bp_stalls", 64'(stall_cnt), 64'd3);
        stall_en = 1'b0;
        rtoggle  = 1'b0;
        check("bp_nwr", 64'(wq_addr.size()), 64'd4);
        for (int i = 0; i < LW; i++) begin
            check("bp_waddr", 64'(wq_addr[i]), 64'(28 + i));
            check("bp_wdata", 64'(wq_data[i]), 64'(32'hE000_0000 + 32'(i)));
        end
        check("bp_nrd", 64'(rq_addr.size()), 64'd4);
        check("bp_stable", 64'(stab_bad), 64'd0);
        check_fills("bp", 0, 0);

        // 4: same line written back and refilled
        for (int i = 0; i < LW; i++) line[i*DW +: DW] = 32'hCAFE_0000 + 32'(i);
        send(5'd12, 1'b1, 5'd12, line, 2'd0);
        wait_done();
        check("same_nfill", 64'(fq_idx.size()), 64'd4);
        for (int i = 0; i < LW; i++) begin
            check("same_fidx", 64'(fq_idx[i]), 64'(i));
            check("same_fdata", 64'(fq_data[i]), 64'(32'hCAFE_0000 + 32'(i)));
        end

        // 5: critical word index 2 on line 20
        s = (CRIT_ON != 0) ? 2 : 0;
        send(5'd20, 1'b0, 5'd0, '0, 2'd2);
        wait_done();
        for (int i = 0; i < LW; i++)
            check("crit_raddr", 64'(rq_addr[i]), 64'(20 + (s + i) % LW));
        check_fills("crit", 20, s);

        // 6: reset after two returns, then a fresh request
        send(5'd8, 1'b0, 5'd0, '0, 2'd0);
        n = 0;
        while (fq_idx.size() < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("mid_two_fills", 64'(fq_idx.size() >= 2), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        rsz = rq_addr.size();
        repeat (3) @(posedge clk);
        #1 check("midrst_no_reads", 64'(rq_addr.size()), 64'(rsz));
        check("midrst_no_done", 64'(dq_cyc.size()), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        send(5'd24, 1'b0, 5'd0, '0, 2'd0);
        wait_done();
        check_fills("after_rst", 24, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
